// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and helpers for the N-digit BCD counter.
//   DIGIT_W    - bits per BCD digit
//   BCD_MAX    - largest legal digit value
//   MAX_DIGITS - widest counter the helpers support (32-bit operands)
//   bcd_valid  - digit is in 0..9
//   bcd_sat    - clamp an illegal digit to 9
//   bcd_ge     - multi-digit magnitude compare, a >= b
package bcd_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;

  function automatic logic bcd_valid(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

  function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
    return bcd_valid(digit) ? digit : BCD_MAX;
  endfunction

  // Operands are zero-extended to MAX_DIGITS digits by the caller.
  // The most significant differing digit decides.
  function automatic logic bcd_ge(input logic [31:0] a, input logic [31:0] b);
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (a[4*i +: 4] != b[4*i +: 4]) begin
        return a[4*i +: 4] > b[4*i +: 4];
      end
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: combinational single-digit BCD step cell.
//   d          - current digit (0..9)
//   inc        - add one to this digit (carry in)
//   dec        - subtract one from this digit (borrow in)
//   d_next     - resulting digit
//   carry_out  - this digit wrapped 9 -> 0 while incrementing
//   borrow_out - this digit wrapped 0 -> 9 while decrementing
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] d_next,
  output logic       carry_out,
  output logic       borrow_out
);

  always_comb begin
    d_next     = d;
    carry_out  = 1'b0;
    borrow_out = 1'b0;
    if (inc) begin
      // >= rather than == so a corrupted digit can never climb past 9
      if (d >= BCD_MAX) begin
        d_next    = 4'd0;
        carry_out = 1'b1;
      end else begin
        d_next = d + 4'd1;
      end
    end else if (dec) begin
      if (d == 4'd0) begin
        d_next     = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        d_next = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-digit BCD up/down counter with programmable wrap
// limit, synchronous clear, validated parallel load and terminal-count pulse.
//   clk, reset_n - clock, asynchronous active-low reset
//   en, up       - count enable and direction (1 = up)
//   clear        - synchronous clear (highest priority)
//   load         - synchronous load of load_value (rejected if any digit > 9)
//   limit        - wrap limit (modulus - 1), illegal digits read as 9
//   count        - registered BCD count
//   tc           - one-cycle pulse in the cycle count shows the wrapped value
//   load_err     - one-cycle pulse after a rejected load
//   zero         - count == 0 (combinational from count)
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clear,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_value,
  input  logic [DIGITS*DIGIT_W-1:0] limit,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      tc,
  output logic                      load_err,
  output logic                      zero
);

  localparam int W = DIGITS * DIGIT_W;

  logic [W-1:0]      count_q, count_d;
  logic              tc_q, tc_d;
  logic              load_err_q, load_err_d;

  logic [W-1:0]      limit_sat;
  logic [W-1:0]      count_step;
  logic [DIGITS-1:0] carry, borrow;
  logic [31:0]       count_ext, limit_ext;
  logic              load_ok;
  logic              unused_top;

  // Digit chain: digit 0 gets the step request, higher digits are fed by the
  // carry/borrow of the digit below. Only one of inc/dec is ever active.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic d_inc, d_dec;
    if (k == 0) begin : g_lsd
      assign d_inc = up;
      assign d_dec = ~up;
    end else begin : g_upper
      assign d_inc = carry[k-1];
      assign d_dec = borrow[k-1];
    end

    bcd_digit u_digit (
      .d          (count_q[DIGIT_W*k +: DIGIT_W]),
      .inc        (d_inc),
      .dec        (d_dec),
      .d_next     (count_step[DIGIT_W*k +: DIGIT_W]),
      .carry_out  (carry[k]),
      .borrow_out (borrow[k])
    );

    assign limit_sat[DIGIT_W*k +: DIGIT_W] = bcd_sat(limit[DIGIT_W*k +: DIGIT_W]);
  end

  // The top digit never carries or borrows: an up-count at all 9s is always
  // >= limit and a down-count at 0 always takes the wrap path.
  assign unused_top = carry[DIGITS-1] | borrow[DIGITS-1];

  always_comb begin
    count_ext        = '0;
    limit_ext        = '0;
    count_ext[W-1:0] = count_q;
    limit_ext[W-1:0] = limit_sat;
  end

  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!bcd_valid(load_value[DIGIT_W*k +: DIGIT_W])) begin
        load_ok = 1'b0;
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_value;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (bcd_ge(count_ext, limit_ext)) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_step;
        end
      end else begin
        if (count_q == '0) begin
          count_d = limit_sat;
          tc_d    = 1'b1;
        end else begin
          count_d = count_step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;
  assign zero     = (count_q == '0);

endmodule
